// File: rtl/cv32e40s_lsu_write_buffer.sv
// cv32e40s_lsu_write_buffer: in-order FIFO that absorbs bufferable stores between the response filter and the OBI bus
package cv32e40s_lsu_write_buffer_pkg;
   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [1:0]  memtype;
      logic [2:0]  prot;
   } obi_data_req_t;
endpackage

module cv32e40s_lsu_write_buffer
   import cv32e40s_lsu_write_buffer_pkg::*;
#(
   parameter int DEPTH     = 2,
   parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid_i,
   input  obi_data_req_t        trans_i,
   output logic                 ready_o,
   output logic                 valid_o,
   output obi_data_req_t        trans_o,
   input  logic                 ready_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 empty_o,
   output logic                 full_o
);
   localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;

   obi_data_req_t        entries [DEPTH];
   logic [PTR_W-1:0]     wptr, rptr;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 buf_store, empty, has_room, push, pop;

   // Passthrough while empty, otherwise drive the head; room is judged on registered cnt to keep ready_i off ready_o
   always_comb begin
      buf_store = trans_i.we && trans_i.memtype[0];
      empty     = cnt == '0;
      has_room  = cnt < CNT_WIDTH'(DEPTH);
      push      = rst_n && valid_i && buf_store && (empty ? !ready_i : has_room);
      pop       = !empty && ready_i;
      valid_o   = rst_n && (empty ? valid_i : 1'b1);
      trans_o   = !rst_n ? '0 : empty ? trans_i : entries[rptr];
      ready_o   = rst_n && (buf_store ? has_room : (empty && ready_i));
      cnt_o     = cnt;
      empty_o   = empty;
      full_o    = !has_room;
   end

   // Storage, pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         wptr <= '0;
         rptr <= '0;
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      end else begin
         if (push) begin
            entries[wptr] <= trans_i;
            wptr          <= wptr == PTR_W'(DEPTH - 1) ? '0 : wptr + 1'b1;
         end
         if (pop) rptr <= rptr == PTR_W'(DEPTH - 1) ? '0 : rptr + 1'b1;
         cnt <= cnt + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
      end
   end

   a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) cnt <= CNT_WIDTH'(DEPTH));
   a_obi_stable: assert property (@(posedge clk) disable iff (!rst_n) valid_o && !ready_i |=> $stable(trans_o));
   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) push |-> has_room);
endmodule

// File: tb/tb_cv32e40s_lsu_write_buffer.sv
// tb_cv32e40s_lsu_write_buffer: directed checks of passthrough, buffering, ordering, wrap and async reset
module tb_cv32e40s_lsu_write_buffer;
   import cv32e40s_lsu_write_buffer_pkg::*;

   logic          clk = 0;
   logic          rst_n = 0;
   logic          valid_i = 0;
   obi_data_req_t trans_i = '0;
   logic          ready_o;
   logic          valid_o;
   obi_data_req_t trans_o;
   logic          ready_i = 0;
   logic [1:0]    cnt_o;
   logic          empty_o;
   logic          full_o;
   int            checks = 0;
   int            failures = 0;

   cv32e40s_lsu_write_buffer #(.DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .trans_i(trans_i), .ready_o(ready_o),
      .valid_o(valid_o), .trans_o(trans_o), .ready_i(ready_i), .cnt_o(cnt_o),
      .empty_o(empty_o), .full_o(full_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Store when st=1 (we=1, memtype[0]=1), load otherwise; settles combinational outputs before returning
   task automatic drive(input logic v, input logic st, input logic [31:0] a, input logic rdy);
      valid_i         = v;
      trans_i         = '0;
      trans_i.addr    = a;
      trans_i.we      = st;
      trans_i.be      = 4'hf;
      trans_i.wdata   = a ^ 32'hdead_0000;
      trans_i.memtype = {1'b0, st};
      ready_i         = rdy;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state, valid_i masked
      drive(1, 0, 32'h100, 1);
      chk("rst_valid", valid_o, 0);
      chk("rst_ready", ready_o, 0);
      chk("rst_cnt", cnt_o, 0);
      chk("rst_empty", empty_o, 1);
      chk("rst_full", full_o, 0);
      chk("rst_trans", trans_o, 0);
      tick();
      tick();
      rst_n = 1;
      // load passthrough
      drive(1, 0, 32'h100, 1);
      chk("ld_valid", valid_o, 1);
      chk("ld_addr", trans_o.addr, 32'h100);
      chk("ld_ready", ready_o, 1);
      tick();
      chk("ld_cnt", cnt_o, 0);
      // bufferable store with bus stall
      drive(1, 1, 32'h200, 0);
      chk("st_ready0", ready_o, 1);
      chk("st_cnt0", cnt_o, 0);
      chk("st_addr0", trans_o.addr, 32'h200);
      tick();
      drive(0, 0, 0, 0);
      chk("st_cnt1", cnt_o, 1);
      chk("st_valid1", valid_o, 1);
      chk("st_addr1", trans_o.addr, 32'h200);
      chk("st_wdata1", trans_o.wdata, 32'hdead_0200);
      tick();
      chk("st_addr2", trans_o.addr, 32'h200);
      drive(0, 0, 0, 1);
      chk("st_addr3", trans_o.addr, 32'h200);
      tick();
      chk("st_cnt_done", cnt_o, 0);
      chk("st_empty_done", empty_o, 1);
      chk("st_valid_done", valid_o, 0);
      // fill A,B; C stalls; drain in order
      drive(1, 1, 32'h300, 0);
      chk("a_ready", ready_o, 1);
      tick();
      drive(1, 1, 32'h304, 0);
      chk("b_ready", ready_o, 1);
      chk("b_head", trans_o.addr, 32'h300);
      tick();
      drive(1, 1, 32'h308, 0);
      chk("c_cnt", cnt_o, 2);
      chk("c_full", full_o, 1);
      chk("c_ready", ready_o, 0);
      tick();
      chk("c_ready_hold", ready_o, 0);
      drive(1, 1, 32'h308, 1);
      chk("c_ready_fullpop", ready_o, 0);
      chk("bus_a", trans_o.addr, 32'h300);
      tick();
      chk("bus_b", trans_o.addr, 32'h304);
      chk("c_ready_go", ready_o, 1);
      chk("c_cnt1", cnt_o, 1);
      tick();
      drive(0, 0, 0, 1);
      chk("bus_c", trans_o.addr, 32'h308);
      chk("c_cnt_keep", cnt_o, 1);
      tick();
      chk("abc_empty", empty_o, 1);
      // load behind pending store
      drive(1, 1, 32'h400, 0);
      tick();
      drive(1, 0, 32'h500, 0);
      chk("l_ready0", ready_o, 0);
      chk("l_head_s", trans_o.addr, 32'h400);
      tick();
      drive(1, 0, 32'h500, 1);
      chk("l_ready1", ready_o, 0);
      chk("l_bus_s", trans_o.addr, 32'h400);
      tick();
      chk("l_cnt", cnt_o, 0);
      chk("l_valid", valid_o, 1);
      chk("l_bus_l", trans_o.addr, 32'h500);
      chk("l_ready2", ready_o, 1);
      tick();
      // simultaneous push/pop with pointer wrap over 5 stores
      drive(1, 1, 32'h600, 0);
      tick();
      for (int i = 1; i < 5; i++) begin
         drive(1, 1, 32'h600 + 32'(4 * i), 1);
         chk("w_head", trans_o.addr, 32'h600 + 32'(4 * (i - 1)));
         chk("w_ready", ready_o, 1);
         chk("w_cnt", cnt_o, 1);
         tick();
      end
      drive(0, 0, 0, 1);
      chk("w_last", trans_o.addr, 32'h610);
      chk("w_cnt_last", cnt_o, 1);
      tick();
      chk("w_empty", empty_o, 1);
      // async reset mid-drain
      drive(1, 1, 32'h700, 0);
      tick();
      drive(1, 1, 32'h704, 0);
      tick();
      drive(0, 0, 0, 0);
      chk("r_cnt2", cnt_o, 2);
      #2;
      rst_n = 0;
      #1;
      chk("r_valid", valid_o, 0);
      chk("r_cnt", cnt_o, 0);
      chk("r_empty", empty_o, 1);
      tick();
      rst_n = 1;
      drive(1, 0, 32'h800, 1);
      chk("r_pass_valid", valid_o, 1);
      chk("r_pass_addr", trans_o.addr, 32'h800);
      chk("r_pass_ready", ready_o, 1);
      tick();
      chk("r_pass_cnt", cnt_o, 0);
      drive(0, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
